// File: rtl/sb_thres_servo_if.sv
// Purpose: control/status bundle between software-facing logic and the threshold servo.
// Latency: pure wiring, no registers.
// Backpressure: none; START/STOP are single-cycle pulses, config must stay stable while BUSY.
//
// master modport: drives ENABLE40, ADC0..2, START/STOP and configuration; reads results.
// slave modport : the servo itself.
interface sb_thres_servo_if #(
    parameter int ADC_WIDTH = 12,
    parameter int WIN_WIDTH = 24,
    parameter int CNT_WIDTH = 16
);
    logic [1:0]           ENABLE40;
    logic [ADC_WIDTH-1:0] ADC0;
    logic [ADC_WIDTH-1:0] ADC1;
    logic [ADC_WIDTH-1:0] ADC2;
    logic                 START;
    logic                 STOP;
    logic [WIN_WIDTH-1:0] WINDOW;
    logic [CNT_WIDTH-1:0] RATE_LO;
    logic [CNT_WIDTH-1:0] RATE_HI;
    logic [3:0]           STEP;
    logic [ADC_WIDTH-1:0] THRES_INIT;
    logic [ADC_WIDTH-1:0] THRES_MIN;
    logic [ADC_WIDTH-1:0] THRES_MAX;
    logic [7:0]           MAX_ITER;

    logic [ADC_WIDTH-1:0] THRES0;
    logic [ADC_WIDTH-1:0] THRES1;
    logic [ADC_WIDTH-1:0] THRES2;
    logic [CNT_WIDTH-1:0] COUNT0;
    logic [CNT_WIDTH-1:0] COUNT1;
    logic [CNT_WIDTH-1:0] COUNT2;
    logic [2:0]           LOCKED;
    logic                 BUSY;
    logic                 DONE;
    logic                 FAIL;

    modport master (
        output ENABLE40, ADC0, ADC1, ADC2, START, STOP, WINDOW, RATE_LO, RATE_HI,
               STEP, THRES_INIT, THRES_MIN, THRES_MAX, MAX_ITER,
        input  THRES0, THRES1, THRES2, COUNT0, COUNT1, COUNT2, LOCKED, BUSY, DONE, FAIL
    );

    modport slave (
        input  ENABLE40, ADC0, ADC1, ADC2, START, STOP, WINDOW, RATE_LO, RATE_HI,
               STEP, THRES_INIT, THRES_MIN, THRES_MAX, MAX_ITER,
        output THRES0, THRES1, THRES2, COUNT0, COUNT1, COUNT2, LOCKED, BUSY, DONE, FAIL
    );
endinterface

// File: rtl/sb_thres_servo.sv
// Purpose: closed-loop servo of the three single-bin trigger thresholds onto a crossing-rate band.
// Latency: one run = n * ((4 + WINDOW) 40 MHz strobes + 1 ADJUST clock); BUSY/THRES_INIT one clock after START.
// Backpressure: none; START ignored while BUSY, STOP aborts from any state on the next clock.
//
// Ports: CLK120 (120 MHz clock), RESET (async, active-high), bus (sb_thres_servo_if.slave):
//   inputs  ENABLE40, ADC0..2, START, STOP, WINDOW, RATE_LO/HI, STEP, THRES_INIT/MIN/MAX, MAX_ITER
//   outputs THRES0..2, COUNT0..2, LOCKED, BUSY, DONE, FAIL
// Build option: define SB_SERVO_TRACK_EN for continuous tracking after the first lock.
module sb_thres_servo #(
    parameter int ADC_WIDTH = 12,
    parameter int WIN_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic              CLK120,
    input  logic              RESET,
    sb_thres_servo_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        ADJUST  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           en40_q;
    logic                 strobe;
    logic [ADC_WIDTH-1:0] adc       [3];
    logic [ADC_WIDTH-1:0] thres     [3];
    logic [ADC_WIDTH-1:0] thres_adj [3];
    logic [CNT_WIDTH-1:0] cnt       [3];
    logic [CNT_WIDTH-1:0] cnt_nxt   [3];
    logic [CNT_WIDTH-1:0] count_q   [3];
    logic [2:0]           flag;
    logic [2:0]           prev_flag;
    logic [2:0]           inband;
    logic [2:0]           locked_q;
    logic [1:0]           settle_cnt;
    logic [WIN_WIDTH-1:0] win_cnt;
    logic [WIN_WIDTH-1:0] win_last_idx;
    logic                 win_last;
    logic                 settle_last;
    logic [7:0]           iter_cnt;
    logic [7:0]           iter_nxt;
    logic                 all_lock;
    logic                 max_hit;
    logic                 start_run;
    logic                 adj_fire;
    logic                 enter_settle;
    logic                 done_set;
    logic                 fail_set;
    logic                 done_q;
    logic                 fail_q;
`ifdef SB_SERVO_TRACK_EN
    logic                 done_seen;
`endif

    // One step of the servo for one PMT. Done one bit wider than the
    // threshold so the increment cannot wrap; the decrement floors at 0,
    // then MIN, then MAX is applied last so MAX wins on a bad configuration.
    function automatic logic [ADC_WIDTH-1:0] adjust_thres(
        input logic [ADC_WIDTH-1:0] thr,
        input logic [CNT_WIDTH-1:0] c,
        input logic [CNT_WIDTH-1:0] lo,
        input logic [CNT_WIDTH-1:0] hi,
        input logic [3:0]           step,
        input logic [ADC_WIDTH-1:0] tmin,
        input logic [ADC_WIDTH-1:0] tmax
    );
        logic [ADC_WIDTH:0] t;
        logic [ADC_WIDTH:0] s;
        logic [ADC_WIDTH:0] r;
        t = {1'b0, thr};
        s = (ADC_WIDTH+1)'(step);
        r = t;
        if (c > hi) begin
            r = t + s;
            if (r > {1'b0, tmax}) r = {1'b0, tmax};
        end else if (c < lo) begin
            r = (t < s) ? '0 : t - s;
            if (r < {1'b0, tmin}) r = {1'b0, tmin};
            if (r > {1'b0, tmax}) r = {1'b0, tmax};
        end
        return r[ADC_WIDTH-1:0];
    endfunction

    assign strobe       = (en40_q == 2'd0);
    assign win_last_idx = (bus.WINDOW == '0) ? '0 : bus.WINDOW - WIN_WIDTH'(1);
    assign win_last     = (state == MEASURE) && strobe && (win_cnt == win_last_idx);
    assign settle_last  = (state == SETTLE) && strobe && (settle_cnt == 2'd3);
    assign iter_nxt     = iter_cnt + 8'd1;
    assign all_lock     = &inband;
    assign max_hit      = (bus.MAX_ITER != 8'd0) && (iter_nxt == bus.MAX_ITER);
    assign enter_settle = (state_nxt == SETTLE) && (state != SETTLE);

    always_comb begin
        adc[0] = bus.ADC0;
        adc[1] = bus.ADC1;
        adc[2] = bus.ADC2;
        for (int i = 0; i < 3; i++) begin
            flag[i]      = adc[i] > thres[i];
            cnt_nxt[i]   = cnt[i];
            if (strobe && flag[i] && !prev_flag[i] && (cnt[i] != {CNT_WIDTH{1'b1}}))
                cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
            inband[i]    = (count_q[i] >= bus.RATE_LO) && (count_q[i] <= bus.RATE_HI);
            thres_adj[i] = adjust_thres(thres[i], count_q[i], bus.RATE_LO, bus.RATE_HI,
                                        bus.STEP, bus.THRES_MIN, bus.THRES_MAX);
        end
    end

    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        adj_fire  = 1'b0;
        done_set  = 1'b0;
        fail_set  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    state_nxt = SETTLE;
                    start_run = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_last) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (win_last) state_nxt = ADJUST;
            end
            ADJUST: begin
                adj_fire = 1'b1;
`ifdef SB_SERVO_TRACK_EN
                state_nxt = SETTLE;
                done_set  = all_lock && !done_seen;
`else
                if (all_lock) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end else if (max_hit) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                    fail_set  = 1'b1;
                end else begin
                    state_nxt = SETTLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        // STOP overrides everything, including a START in the same cycle.
        if (bus.STOP) begin
            state_nxt = IDLE;
            start_run = 1'b0;
            adj_fire  = 1'b0;
            done_set  = 1'b0;
            fail_set  = 1'b0;
        end
    end

    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            en40_q     <= 2'd3;
            prev_flag  <= 3'b111;
            settle_cnt <= 2'd0;
            win_cnt    <= '0;
            iter_cnt   <= 8'd0;
            locked_q   <= 3'b000;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
`ifdef SB_SERVO_TRACK_EN
            done_seen  <= 1'b0;
`endif
            for (int i = 0; i < 3; i++) begin
                thres[i]   <= {ADC_WIDTH{1'b1}};
                cnt[i]     <= '0;
                count_q[i] <= '0;
            end
        end else begin
            en40_q <= bus.ENABLE40;
            done_q <= done_set;

            // Preset to "already above" so a baseline sitting over the
            // threshold is not mistaken for a crossing.
            if (enter_settle)
                prev_flag <= 3'b111;
            else if (strobe && (state == SETTLE || state == MEASURE))
                prev_flag <= flag;

            if (enter_settle)
                settle_cnt <= 2'd0;
            else if (state == SETTLE && strobe)
                settle_cnt <= settle_cnt + 2'd1;

            if (settle_last)
                win_cnt <= '0;
            else if (state == MEASURE && strobe)
                win_cnt <= win_cnt + WIN_WIDTH'(1);

            for (int i = 0; i < 3; i++) begin
                if (settle_last)
                    cnt[i] <= '0;
                else if (state == MEASURE && strobe)
                    cnt[i] <= cnt_nxt[i];

                if (win_last && !bus.STOP)
                    count_q[i] <= cnt_nxt[i];

                if (start_run)
                    thres[i] <= bus.THRES_INIT;
                else if (adj_fire)
                    thres[i] <= thres_adj[i];
            end

            if (start_run) begin
                locked_q <= 3'b000;
                iter_cnt <= 8'd0;
                fail_q   <= 1'b0;
            end else if (adj_fire) begin
                locked_q <= inband;
                iter_cnt <= iter_nxt;
            end
            if (fail_set) fail_q <= 1'b1;

`ifdef SB_SERVO_TRACK_EN
            if (start_run)     done_seen <= 1'b0;
            else if (done_set) done_seen <= 1'b1;
`endif
        end
    end

    assign bus.THRES0 = thres[0];
    assign bus.THRES1 = thres[1];
    assign bus.THRES2 = thres[2];
    assign bus.COUNT0 = count_q[0];
    assign bus.COUNT1 = count_q[1];
    assign bus.COUNT2 = count_q[2];
    assign bus.LOCKED = locked_q;
    assign bus.BUSY   = (state != IDLE);
    assign bus.DONE   = done_q;
    assign bus.FAIL   = fail_q;

endmodule

// File: tb/tb_sb_thres_servo.sv
// Purpose: directed self-checking bench for sb_thres_servo (counter width 4 so saturation is reachable).
// Latency: n/a.
// Backpressure: n/a.
module tb_sb_thres_servo;

    localparam int AW = 12;
    localparam int WW = 24;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sb_thres_servo_if #(.ADC_WIDTH(AW), .WIN_WIDTH(WW), .CNT_WIDTH(CW)) bus ();

    sb_thres_servo #(.ADC_WIDTH(AW), .WIN_WIDTH(WW), .CNT_WIDTH(CW)) dut (
        .CLK120 (clk),
        .RESET  (rst),
        .bus    (bus)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [23:0] win;
        logic [3:0]  lo;
        logic [3:0]  hi;
        logic [3:0]  step;
        logic [11:0] init;
        logic [11:0] tmin;
        logic [11:0] tmax;
        logic [7:0]  maxit;
        int          p0;
        int          p1;
        int          p2;
        logic        lvl;
        logic [11:0] amp;
        int          budget;
        logic [11:0] t0;
        logic [11:0] t1;
        logic [11:0] t2;
        logic [3:0]  c0;
        logic [3:0]  c1;
        logic [3:0]  c2;
        logic [2:0]  lk;
        logic        fl;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    // Pulse generator configuration: one high sample every pN strobes,
    // or a constant level when lvl is set.
    int          cfg_p0 = 7;
    int          cfg_p1 = 7;
    int          cfg_p2 = 7;
    logic        cfg_lvl = 1'b0;
    logic [11:0] cfg_amp = 12'd0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // 40 MHz phase and ADC samples, each sample held for one full strobe period.
    initial begin
        int ph;
        int k;
        ph = 0;
        k  = 0;
        bus.ENABLE40 = 2'd0;
        bus.ADC0 = '0;
        bus.ADC1 = '0;
        bus.ADC2 = '0;
        forever begin
            @(negedge clk);
            ph = (ph == 2) ? 0 : ph + 1;
            bus.ENABLE40 = 2'(ph);
            if (ph == 0) begin
                k++;
                bus.ADC0 = (cfg_lvl || (k % cfg_p0) == 0) ? cfg_amp : 12'd0;
                bus.ADC1 = (cfg_lvl || (k % cfg_p1) == 0) ? cfg_amp : 12'd0;
                bus.ADC2 = (cfg_lvl || (k % cfg_p2) == 0) ? cfg_amp : 12'd0;
            end
        end
    end

    always @(negedge clk) if (bus.DONE === 1'b1) done_cnt++;

    task automatic apply_cfg(input vec_t v);
        bus.WINDOW     = v.win;
        bus.RATE_LO    = v.lo;
        bus.RATE_HI    = v.hi;
        bus.STEP       = v.step;
        bus.THRES_INIT = v.init;
        bus.THRES_MIN  = v.tmin;
        bus.THRES_MAX  = v.tmax;
        bus.MAX_ITER   = v.maxit;
        cfg_p0  = v.p0;
        cfg_p1  = v.p1;
        cfg_p2  = v.p2;
        cfg_lvl = v.lvl;
        cfg_amp = v.amp;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    vec_t vt [11];

    initial begin
        int d0;
        bit got;
        bus.START = 1'b0;
        bus.STOP  = 1'b0;

        //       win     lo    hi    step  init     min      max       it    p0 p1 p2 lvl amp     budget t0       t1       t2       c0     c1     c2     lk      fl
        vt[0]  = '{24'd100,4'd3,4'd5,4'd8, 12'd100,12'd0,  12'd4000,8'd0, 25,25,25,1'b0,12'd200,1000,12'd100,12'd100,12'd100,4'd4, 4'd4, 4'd4, 3'b111,1'b0};
        vt[1]  = '{24'd100,4'd0,4'd2,4'd8, 12'd100,12'd0,  12'd4000,8'd0, 10,10,10,1'b0,12'd200,6000,12'd204,12'd204,12'd204,4'd0, 4'd0, 4'd0, 3'b111,1'b0};
        vt[2]  = '{24'd100,4'd0,4'd2,4'd15,12'd100,12'd0,  12'd120, 8'd5, 10,10,10,1'b0,12'd200,2500,12'd120,12'd120,12'd120,4'd10,4'd10,4'd10,3'b000,1'b1};
        vt[3]  = '{24'd30, 4'd0,4'd0,4'd8, 12'd100,12'd0,  12'd4000,8'd3, 7, 7, 7, 1'b1,12'd200,500, 12'd100,12'd100,12'd100,4'd0, 4'd0, 4'd0, 3'b111,1'b0};
        vt[4]  = '{24'd100,4'd0,4'd2,4'd3, 12'd100,12'd0,  12'd4000,8'd1, 5, 5, 5, 1'b0,12'd200,500, 12'd103,12'd103,12'd103,4'd15,4'd15,4'd15,3'b000,1'b1};
        vt[5]  = '{24'd30, 4'd1,4'd15,4'd10,12'd100,12'd85,12'd4000,8'd2, 7, 7, 7, 1'b0,12'd50, 500, 12'd85, 12'd85, 12'd85, 4'd0, 4'd0, 4'd0, 3'b000,1'b1};
        vt[6]  = '{24'd100,4'd3,4'd5,4'd4, 12'd100,12'd0,  12'd4000,8'd1, 25,10,5, 1'b0,12'd200,500, 12'd100,12'd104,12'd104,4'd4, 4'd10,4'd15,3'b001,1'b1};
        vt[7]  = '{24'd100,4'd5,4'd3,4'd4, 12'd100,12'd0,  12'd4000,8'd2, 25,25,25,1'b0,12'd200,900, 12'd108,12'd108,12'd108,4'd4, 4'd4, 4'd4, 3'b000,1'b1};
        vt[8]  = '{24'd0,  4'd0,4'd0,4'd8, 12'd100,12'd0,  12'd4000,8'd0, 7, 7, 7, 1'b0,12'd0,  40,  12'd100,12'd100,12'd100,4'd0, 4'd0, 4'd0, 3'b111,1'b0};
        vt[9]  = '{24'd10, 4'd1,4'd15,4'd10,12'd5, 12'd150,12'd120, 8'd1, 7, 7, 7, 1'b0,12'd0,  200, 12'd120,12'd120,12'd120,4'd0, 4'd0, 4'd0, 3'b000,1'b1};
        vt[10] = '{24'd10, 4'd1,4'd15,4'd10,12'd5, 12'd0,  12'd4000,8'd1, 7, 7, 7, 1'b0,12'd0,  200, 12'd0,  12'd0,  12'd0,  4'd0, 4'd0, 4'd0, 3'b000,1'b1};

        apply_cfg(vt[0]);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_thres0", int'(bus.THRES0), 4095);
        chk("rst_thres2", int'(bus.THRES2), 4095);
        chk("rst_count1", int'(bus.COUNT1), 0);
        chk("rst_locked", int'(bus.LOCKED), 0);
        chk("rst_busy",   int'(bus.BUSY), 0);
        chk("rst_done",   int'(bus.DONE), 0);
        chk("rst_fail",   int'(bus.FAIL), 0);

        // Reset while in ADJUST: COUNT just latched, THRES/LOCKED not yet updated.
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.COUNT0 != '0) begin
                got = 1'b1;
                break;
            end
        end
        chk("adj_reached", int'(got), 1);
        chk("adj_count0",  int'(bus.COUNT0), 4);
        chk("adj_locked",  int'(bus.LOCKED), 0);
        chk("adj_thres0",  int'(bus.THRES0), 100);
        chk("adj_busy",    int'(bus.BUSY), 1);
        rst = 1'b1;
        #1;
        chk("arst_thres1", int'(bus.THRES1), 4095);
        chk("arst_count0", int'(bus.COUNT0), 0);
        chk("arst_locked", int'(bus.LOCKED), 0);
        chk("arst_busy",   int'(bus.BUSY), 0);
        chk("arst_done",   int'(bus.DONE), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_no_done", done_cnt, 0);

        // Table-driven runs.
        for (int v = 0; v < 11; v++) begin
            apply_cfg(vt[v]);
            repeat (3) @(negedge clk);
            d0 = done_cnt;
            pulse_start();
            got = 1'b0;
            for (int c = 0; c < vt[v].budget; c++) begin
                @(negedge clk);
                if (bus.DONE === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("v%0d_done_seen", v), int'(got), 1);
            chk($sformatf("v%0d_busy_at_done", v), int'(bus.BUSY), 0);
            chk($sformatf("v%0d_thres0", v), int'(bus.THRES0), int'(vt[v].t0));
            chk($sformatf("v%0d_thres1", v), int'(bus.THRES1), int'(vt[v].t1));
            chk($sformatf("v%0d_thres2", v), int'(bus.THRES2), int'(vt[v].t2));
            chk($sformatf("v%0d_count0", v), int'(bus.COUNT0), int'(vt[v].c0));
            chk($sformatf("v%0d_count1", v), int'(bus.COUNT1), int'(vt[v].c1));
            chk($sformatf("v%0d_count2", v), int'(bus.COUNT2), int'(vt[v].c2));
            chk($sformatf("v%0d_locked", v), int'(bus.LOCKED), int'(vt[v].lk));
            chk($sformatf("v%0d_fail", v),   int'(bus.FAIL),   int'(vt[v].fl));
            @(negedge clk);
            chk($sformatf("v%0d_done_width", v), int'(bus.DONE), 0);
            chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
        end

        // START timing and abort by STOP during MEASURE (FAIL is 1 from the last vector).
        cfg_p0 = 25; cfg_p1 = 25; cfg_p2 = 25; cfg_lvl = 1'b0; cfg_amp = 12'd200;
        bus.WINDOW = 24'd100; bus.RATE_LO = 4'd3; bus.RATE_HI = 4'd5;
        bus.THRES_INIT = 12'd77; bus.MAX_ITER = 8'd0;
        d0 = done_cnt;
        pulse_start();
        chk("start_busy",   int'(bus.BUSY), 1);
        chk("start_thres0", int'(bus.THRES0), 77);
        chk("start_thres2", int'(bus.THRES2), 77);
        chk("start_fail_clr", int'(bus.FAIL), 0);
        repeat (60) @(negedge clk);
        bus.STOP = 1'b1;
        @(negedge clk);
        bus.STOP = 1'b0;
        chk("stop_busy",   int'(bus.BUSY), 0);
        chk("stop_thres0", int'(bus.THRES0), 77);
        chk("stop_count1", int'(bus.COUNT1), 0);
        chk("stop_fail",   int'(bus.FAIL), 0);
        repeat (5) @(negedge clk);
        chk("stop_no_done", done_cnt - d0, 0);

        // START and STOP together: STOP wins, nothing loaded.
        bus.THRES_INIT = 12'd55;
        @(negedge clk);
        bus.START = 1'b1;
        bus.STOP  = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        chk("startstop_busy",   int'(bus.BUSY), 0);
        chk("startstop_thres0", int'(bus.THRES0), 77);

        // START while BUSY is ignored.
        pulse_start();
        chk("run2_thres0", int'(bus.THRES0), 55);
        bus.THRES_INIT = 12'd33;
        pulse_start();
        chk("busy_start_ignored", int'(bus.THRES1), 55);
        bus.STOP = 1'b1;
        @(negedge clk);
        bus.STOP = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_no_done", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sb_thres_servo.md
# sb_thres_servo

Closed-loop threshold controller for the 40 MHz compatibility single-bin trigger. It measures per-PMT threshold-crossing counts over a programmable window of 40 MHz samples, then steps each PMT threshold up or down until every count sits inside a target band. It sits beside the single-bin trigger and drives that trigger's THRES0..2 inputs. Software starts a run and reads back the results.

## Interface
- ADC_WIDTH, `ADC_WIDTH` (12): sample and threshold width.
- WIN_WIDTH, 24: window length counter width.
- CNT_WIDTH, 16: crossing counter width.
- CLK120  in  1  120 MHz system clock.
- RESET  in  1  reset, asynchronous, active-high.
- ENABLE40  in  2  40 MHz phase; value 0 marks the sample cycle.
- ADC0, ADC1, ADC2  in  ADC_WIDTH  PMT samples.
- START  in  1  single-cycle pulse; begins a servo run.
- STOP  in  1  single-cycle pulse; aborts the run.
- WINDOW  in  WIN_WIDTH  40 MHz samples per measurement window; a value of 0 is treated as 1.
- RATE_LO, RATE_HI  in  CNT_WIDTH  inclusive acceptance band for the counts.
- STEP  in  4  threshold increment in ADC counts.
- THRES_INIT, THRES_MIN, THRES_MAX  in  ADC_WIDTH  start value and clamp limits.
- MAX_ITER  in  8  number of windows before the run fails; 0 means unlimited.
- THRES0, THRES1, THRES2  out  ADC_WIDTH  current thresholds.
- COUNT0, COUNT1, COUNT2  out  CNT_WIDTH  counts from the last completed window.
- LOCKED  out  3  per-PMT in-band flags from the last ADJUST.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse at the end of a run.
- FAIL  out  1  sticky; set when MAX_ITER is exhausted, cleared by START.

## Operation
- Sample strobe S: ENABLE40 is registered once locally; S is asserted in the cycle where the registered value is 0. All counting happens on S.
- Crossing on PMT i: a rising edge of the flag (ADC_i > THRES_i), strict compare, evaluated on S against the previous S. The previous-flag register is forced to 1 on entry to SETTLE, so a baseline already above threshold does not count.
- Crossing counters saturate at 2^CNT_WIDTH−1.
- States:
  - IDLE: waits for START. On START, load THRES_INIT into all three thresholds, clear FAIL, clear LOCKED, clear the iteration counter, go to SETTLE.
  - SETTLE: discard 4 strobes, covering the trigger pipeline and threshold propagation. Then clear the crossing counters and the window counter, go to MEASURE.
  - MEASURE: count crossings. After WINDOW strobes, latch the counts into COUNT0..2, go to ADJUST.
  - ADJUST: one cycle, applied per PMT i:
    - count > RATE_HI: THRES_i ← min(THRES_i+STEP, THRES_MAX).
    - count < RATE_LO: THRES_i ← max(THRES_i−STEP, THRES_MIN).
    - otherwise: set LOCKED[i] and leave THRES_i unchanged.
    - Arithmetic is done in ADC_WIDTH+1 bits. The subtraction floors at 0 before the MIN clamp. The MAX clamp is applied last, so it wins if MIN > MAX.
    - Increment the iteration counter.
    - Exit: if LOCKED==3'b111, go to IDLE and pulse DONE. Else if the iteration count equals MAX_ITER (nonzero), set FAIL, pulse DONE, go to IDLE. Else go to SETTLE.
- STOP in any state: go to IDLE on the next clock. THRES and COUNT keep their values, no DONE pulse, FAIL is unchanged.
- START and STOP in the same cycle: STOP wins.
- START while BUSY: ignored.
- RATE_LO > RATE_HI: no count can be in band. The run ends only by FAIL (or never, if MAX_ITER=0).
- Inputs are sampled live. Software must hold them stable while BUSY.

## Timing
- Reset values:
  - THRES0..2 = all-ones, so the trigger is quiet.
  - COUNT0..2 = 0, LOCKED = 0.
  - BUSY, DONE, FAIL = 0; state = IDLE.
- BUSY rises the clock after START. THRES_INIT is visible on THRES0..2 that same clock.
- One window takes 4 + WINDOW strobes plus 1 ADJUST clock; strobes are 3 clocks apart.
- COUNT outputs update on the clock that enters ADJUST. THRES and LOCKED update on the clock leaving ADJUST, coincident with DONE.
- DONE is exactly 1 clock wide. BUSY falls in the same cycle that DONE rises.
- RESET mid-run: all outputs return to their reset values asynchronously; no DONE pulse.

## Configuration
- SB_SERVO_TRACK_EN defined:
  - After a lock, ADJUST returns to SETTLE instead of IDLE, giving continuous tracking.
  - DONE pulses once, at the first full lock. BUSY stays high until STOP.
  - In tracking mode the MAX_ITER check is disabled.
- Undefined: the run terminates at lock or FAIL as described in Operation.

## Test plan
- Lock at the first window: WINDOW=100, band 3..5, drive 4 pulses per window on every PMT → DONE after 1 window, LOCKED=7, THRES0..2=THRES_INIT, COUNT=4.
- Rate too high: pulse amplitude 200, THRES_INIT=100, STEP=8, 10 crossings per window, band 0..2 → THRES steps 108, 116, … ; when THRES reaches 200 the count is 0 and the PMT locks.
- Clamp: THRES_MAX=120, STEP=15, rate stays high, MAX_ITER=5 → THRES sequence 115, 120, 120, 120, 120; FAIL=1; DONE once.
- Sustained level: ADC held above THRES for the whole window → COUNT=0, so the previous-flag preset is verified.
- STOP during MEASURE, and START+STOP in the same cycle → IDLE next clock, no DONE, THRES retained. RESET mid-ADJUST → all outputs at reset values.
- Saturation: CNT_WIDTH=4, 20 crossings in a window → COUNT=15; THRES increments by STEP.
